// File: rtl/fp8_div_e5m2_seq.sv
// Sequential E5M2 divider: restoring radix-2 mantissa division, one quotient bit per cycle,
// followed by a single normalise/round cycle. Valid/ready on both sides, one op in flight.
module fp8_div_e5m2_seq #(
    parameter int unsigned N    = 8,
    parameter int unsigned E    = 5,
    parameter int unsigned MA   = 2,
    parameter int unsigned BIAS = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] y,
    output logic         dz,
    output logic         of,
    output logic         uf
);

    localparam int unsigned QW = 2 * MA + 2;
    localparam int unsigned CW = $clog2(QW);
    localparam int unsigned XW = E + 2;
    localparam int unsigned SB = QW - 3 - MA;
    localparam logic [QW-1:0]        SMASK = QW'((1 << SB) - 1);
    localparam logic signed [XW-1:0] EZERO = '0;
    localparam logic signed [XW-1:0] EMAX  = XW'((1 << E) - 1);

    typedef enum logic [1:0] {StIdle, StDiv, StNorm, StHold} state_e;

    state_e          r_state;
    state_e          w_state_next;

    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic [MA:0]     r_d;
    logic [MA+1:0]   r_rem;
    logic [QW-1:0]   r_q;
    logic [CW-1:0]   r_cnt;
    logic [N-1:0]    r_y;
    logic            r_dz;
    logic            r_of;
    logic            r_uf;

    logic            w_ge;
    logic [MA+1:0]   w_rem_sub;
    logic [QW-1:0]   w_qn;
    logic [MA-1:0]   w_mant;
    logic            w_g;
    logic            w_r;
    logic            w_s;
    logic [MA:0]     w_rnd;
    logic signed [XW-1:0] w_ex;
    logic            w_sign;
    logic            w_a_zero;
    logic            w_b_zero;
    logic [N-1:0]    w_y;
    logic            w_dz;
    logic            w_of;
    logic            w_uf;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: if (in_valid) w_state_next = StDiv;
            StDiv:  if (r_cnt == CW'(QW - 1)) w_state_next = StNorm;
            StNorm: w_state_next = StHold;
            StHold: if (out_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (r_state == StIdle);
        out_valid = (r_state == StHold);
        y         = r_y;
        dz        = r_dz;
        of        = r_of;
        uf        = r_uf;
    end

    // One restoring step: subtract divisor when it fits, then shift the partial remainder.
    always_comb begin
        w_ge      = (r_rem >= {1'b0, r_d});
        w_rem_sub = w_ge ? (r_rem - {1'b0, r_d}) : r_rem;
    end

    // Normalise the quotient so the leading one sits at the top, then round and range-check.
    always_comb begin
        w_qn     = r_q[QW-1] ? r_q : {r_q[QW-2:0], 1'b0};
        w_mant   = w_qn[QW-2 -: MA];
        w_g      = w_qn[QW-2-MA];
        w_r      = w_qn[QW-3-MA];
        w_s      = (|(w_qn & SMASK)) | (r_rem != '0);
        w_rnd    = {1'b0, w_mant} + (MA + 1)'(w_g & (w_r | w_s));
        w_ex     = XW'(r_a[N-2 -: E]) - XW'(r_b[N-2 -: E]) + XW'(BIAS)
                   - XW'(!r_q[QW-1]) + XW'(w_rnd[MA]);
        w_sign   = r_a[N-1] ^ r_b[N-1];
        w_a_zero = (r_a[N-2:0] == '0);
        w_b_zero = (r_b[N-2:0] == '0);

        w_y  = {w_sign, w_ex[E-1:0], w_rnd[MA-1:0]};
        w_dz = 1'b0;
        w_of = 1'b0;
        w_uf = 1'b0;
        if (w_b_zero) begin
            w_y  = {w_sign, {E{1'b1}}, {MA{1'b0}}};
            w_dz = 1'b1;
        end else if (w_a_zero) begin
            w_y  = {w_sign, {(N - 1){1'b0}}};
        end else if (w_ex <= EZERO) begin
            w_y  = {w_sign, {(N - 1){1'b0}}};
            w_uf = 1'b1;
        end else if (w_ex >= EMAX) begin
            w_y  = {w_sign, {E{1'b1}}, {MA{1'b0}}};
            w_of = 1'b1;
        end
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_d   <= '0;
            r_rem <= '0;
            r_q   <= '0;
            r_cnt <= '0;
            r_y   <= '0;
            r_dz  <= 1'b0;
            r_of  <= 1'b0;
            r_uf  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_d   <= {1'b1, b[MA-1:0]};
                        r_rem <= {2'b01, a[MA-1:0]};
                        r_q   <= '0;
                        r_cnt <= '0;
                    end
                end
                StDiv: begin
                    r_q   <= {r_q[QW-2:0], w_ge};
                    r_rem <= w_rem_sub << 1;
                    r_cnt <= r_cnt + CW'(1);
                end
                StNorm: begin
                    r_y  <= w_y;
                    r_dz <= w_dz;
                    r_of <= w_of;
                    r_uf <= w_uf;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp8_div_e5m2_seq.sv
// Self-checking bench for fp8_div_e5m2_seq: directed cases, backpressure, mid-op reset and
// randomized operands against an exact-ratio reference model.
module tb_fp8_div_e5m2_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic       dz;
    logic       of;
    logic       uf;

    int n_assert = 0;
    int n_fail   = 0;

    fp8_div_e5m2_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .dz        (dz),
        .of        (of),
        .uf        (uf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Exact ratio of the significands, rounded up only when the discarded part exceeds one half.
    function automatic logic [10:0] ref_div(input logic [7:0] fa, input logic [7:0] fb);
        int ea, eb, ma, mb, num, ex, sig, r;
        logic s;
        logic [4:0] e5;
        logic [1:0] m2;
        s = fa[7] ^ fb[7];
        if (fb[6:0] == 7'h00) return {3'b100, s, 7'h7C};
        if (fa[6:0] == 7'h00) return {3'b000, s, 7'h00};
        ea = int'(fa[6:2]);
        eb = int'(fb[6:2]);
        ma = 4 + int'(fa[1:0]);
        mb = 4 + int'(fb[1:0]);
        if (ma >= mb) begin
            num = ma;
            ex  = ea - eb + 15;
        end else begin
            num = 2 * ma;
            ex  = ea - eb + 14;
        end
        sig = (num * 4) / mb;
        r   = (num * 4) % mb;
        if (2 * r > mb) sig++;
        if (sig == 8) begin
            sig = 4;
            ex++;
        end
        if (ex <= 0)  return {3'b001, s, 7'h00};
        if (ex >= 31) return {3'b010, s, 7'h7C};
        e5 = 5'(ex);
        m2 = 2'(sig - 4);
        return {3'b000, s, e5, m2};
    endfunction

    task automatic issue(input logic [7:0] ta, input logic [7:0] tb_b);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        a        = ta;
        b        = tb_b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("busy_in_ready", 32'(in_ready), 32'd0);
    endtask

    task automatic wait_result(input string tag, input logic [10:0] exp);
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd7);
        check({tag, "_y"}, 32'(y), 32'(exp[7:0]));
        check({tag, "_flags"}, 32'({dz, of, uf}), 32'(exp[10:8]));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_released"}, 32'(out_valid), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_b,
                          input logic [10:0] exp);
        issue(ta, tb_b);
        wait_result(tag, exp);
    endtask

    initial begin
        logic [7:0]  ra;
        logic [7:0]  rb;
        int          seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 8'h00;
        b         = 8'h00;

        #3;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_y", 32'(y), 32'd0);
        check("reset_flags", 32'({dz, of, uf}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_in_ready", 32'(in_ready), 32'd1);

        // Directed values; expected {dz,of,uf,y}
        run_op("one_by_one",  8'h3C, 8'h3C, {3'b000, 8'h3C});
        run_op("one_by_1p5",  8'h3C, 8'h3E, {3'b000, 8'h39});
        run_op("two_by_one",  8'h40, 8'h3C, {3'b000, 8'h40});
        run_op("neg_by_one",  8'hBC, 8'h3C, {3'b000, 8'hBC});
        run_op("div_zero",    8'h3C, 8'h00, {3'b100, 8'h7C});
        run_op("neg_div_zero", 8'hBC, 8'h00, {3'b100, 8'hFC});
        run_op("zero_divd",   8'h00, 8'h3E, {3'b000, 8'h00});
        run_op("overflow",    8'h7B, 8'h04, {3'b010, 8'h7C});
        run_op("underflow",   8'h04, 8'h7B, {3'b001, 8'h00});

        // Backpressure: result must hold while new operands wait upstream
        issue(8'h40, 8'h3C);
        seen = 0;
        while (!out_valid && seen < 20) begin
            @(posedge clk);
            #1;
            seen++;
        end
        check("bp_latency", 32'(seen), 32'd7);
        a        = 8'h3E;
        b        = 8'h3C;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_y_stable", 32'(y), 32'h40);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_accept", 32'(in_ready), 32'd0);
        wait_result("bp_next", {3'b000, 8'h3E});

        // Reset while the divider is mid-way through its iterations
        issue(8'h3C, 8'h3E);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_y", 32'(y), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_release_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("midrst_no_result", 32'(seen), 32'd0);
        run_op("after_reset", 8'h3C, 8'h3C, {3'b000, 8'h3C});

        // Randomized operands, occasionally zero dividend or divisor
        for (int i = 0; i < 150; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 15) == 0) rb[6:0] = 7'h00;
            if ($urandom_range(0, 15) == 0) ra[6:0] = 7'h00;
            run_op("random", ra, rb, ref_div(ra, rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
